load_align_unit: RTL and testbench

- Parametrised load path stage between the MEM stage and data memory.
- Accepts a load request (byte address plus funct3), issues one or two aligned word reads, and merges the returned words.
- Shifts the merged data to the byte offset and sign- or zero-extends it to XLEN.
- Returns the result to writeback over a valid/ready handshake.
- Adds two things the single-word, purely combinational load extension path lacks: misaligned loads that cross a word boundary, and RV64 widths (LD/LWU).

---
 rtl/load_pkg.sv | 31 +++
 rtl/load_extend.sv | 36 +++
 rtl/load_align_unit.sv | 126 ++++++++++++
 tb/tb_load_align_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared definitions for the load alignment path: funct3 codes, FSM encoding
// and the per-XLEN funct3 legality check.
package load_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // LD and LWU only exist on RV64.
  function automatic logic legal_funct3(input logic [2:0] funct3, input int unsigned xlen);
    case (funct3)
      LB, LH, LW, LBU, LHU: return 1'b1;
      LD, LWU:              return (xlen == 64);
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational shift-by-offset, size select and sign/zero extension of a
// two-word merge value. Shared with the store alignment path.
module load_extend #(
  parameter  int XLEN  = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFS_W = $clog2(NB)
) (
  input  logic [2*XLEN-1:0] merged,
  input  logic [OFS_W-1:0]  offset,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   data
);

  logic [2*XLEN-1:0] shifted;
  logic [3:0]        nbytes;
  logic              top_bit;
  logic              fill;

  always_comb begin
    shifted = merged >> {offset, 3'b000};
    nbytes  = 4'd1 << funct3[1:0];
    case (funct3[1:0])
      2'b00:   top_bit = shifted[7];
      2'b01:   top_bit = shifted[15];
      2'b10:   top_bit = shifted[31];
      default: top_bit = shifted[63];
    endcase
    // funct3[2] marks the unsigned variants.
    fill = ~funct3[2] & top_bit;
    data = '0;
    for (int i = 0; i < XLEN; i++) begin
      data[i] = (i < 8 * int'(nbytes)) ? shifted[i] : fill;
    end
  end

endmodule

// File: rtl/load_align_unit.sv
// Load path stage: issues one or two aligned word reads per load, merges and
// extends the bytes, and hands the result to writeback.
module load_align_unit
  import load_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int ADDR_W = 32,
  localparam int NB     = XLEN / 8,
  localparam int OFS_W  = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_split,
  output logic              rsp_err,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // valid, once raised, holds its payload stable until that edge and never
  // looks at its own ready.

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [OFS_W-1:0]  ofs_q;
  logic [2:0]        f3_q;
  logic              split_q;
  logic [XLEN-1:0]   word0_q;

  logic              accept;
  logic              req_legal;
  logic [OFS_W:0]    req_size;
  logic              req_split;
  logic              err_now;
  logic              resp_entry;
  logic [XLEN-1:0]   ext_w0, ext_w1, ext_data;

  assign accept    = req_valid & req_ready;
  assign req_legal = legal_funct3(req_funct3, XLEN);
  assign req_size  = (OFS_W+1)'(1) << req_funct3[1:0];
  assign req_split = ({1'b0, req_addr[OFS_W-1:0]} + req_size) > (OFS_W+1)'(NB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)        state_d = req_legal ? ST_REQ0 : ST_RESP;
      ST_REQ0:  if (mem_req_ready) state_d = ST_WAIT0;
      ST_WAIT0: if (mem_rsp_valid) state_d = split_q ? ST_REQ1 : ST_RESP;
      ST_REQ1:  if (mem_req_ready) state_d = ST_WAIT1;
      ST_WAIT1: if (mem_rsp_valid) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready)     state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == ST_IDLE);
    mem_req_valid = (state_q == ST_REQ0) || (state_q == ST_REQ1);
    rsp_valid     = (state_q == ST_RESP);
    dbg_state     = state_q;
    case (state_q)
      ST_REQ0: mem_req_addr = base_q;
      ST_REQ1: mem_req_addr = base_q + ADDR_W'(NB);
      default: mem_req_addr = '0;
    endcase
  end

  // The arriving word feeds the merge directly so the result can be
  // registered on the same edge that enters RESP.
  assign ext_w0 = (state_q == ST_WAIT0) ? mem_rsp_data : word0_q;
  assign ext_w1 = (state_q == ST_WAIT1) ? mem_rsp_data : '0;

  load_extend #(.XLEN(XLEN)) u_extend (
    .merged (({ext_w1, ext_w0})),
    .offset (ofs_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  // An illegal request jumps straight from IDLE, before err is latched.
  assign err_now    = (state_q == ST_IDLE) ? ~req_legal : 1'b0;
  assign resp_entry = (state_d == ST_RESP) && (state_q != ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      ofs_q     <= '0;
      f3_q      <= '0;
      split_q   <= 1'b0;
      word0_q   <= '0;
      rsp_data  <= '0;
      rsp_split <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        base_q  <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        ofs_q   <= req_addr[OFS_W-1:0];
        f3_q    <= req_funct3;
        split_q <= req_split & req_legal;
      end
      if (state_q == ST_WAIT0 && mem_rsp_valid) word0_q <= mem_rsp_data;
      if (resp_entry) begin
        rsp_err   <= err_now;
        rsp_data  <= err_now ? '0 : ext_data;
        rsp_split <= err_now ? 1'b0 : split_q;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: an XLEN=32 and an XLEN=64 instance
// driven by hand-computed load vectors with a scripted memory.
module tb_load_align_unit;
  import load_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // XLEN=32 instance
  logic        req_valid = 0, mem_req_ready = 0, mem_rsp_valid = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, mem_rsp_data = 0;
  logic [2:0]  req_funct3 = 0;
  logic        req_ready, mem_req_valid, rsp_valid, rsp_split, rsp_err;
  logic [31:0] mem_req_addr, rsp_data;
  logic [2:0]  dbg_state;

  // XLEN=64 instance
  logic        req_valid_64 = 0, mem_req_ready_64 = 0, mem_rsp_valid_64 = 0, rsp_ready_64 = 0;
  logic [31:0] req_addr_64 = 0;
  logic [63:0] mem_rsp_data_64 = 0;
  logic [2:0]  req_funct3_64 = 0;
  logic        req_ready_64, mem_req_valid_64, rsp_valid_64, rsp_split_64, rsp_err_64;
  logic [31:0] mem_req_addr_64;
  logic [63:0] rsp_data_64;
  logic [2:0]  dbg_state_64;

  int n_checks = 0;
  int n_pass   = 0;

  load_align_unit #(.XLEN(32), .ADDR_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_split(rsp_split), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  load_align_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_64), .req_ready(req_ready_64), .req_addr(req_addr_64), .req_funct3(req_funct3_64),
    .mem_req_valid(mem_req_valid_64), .mem_req_ready(mem_req_ready_64), .mem_req_addr(mem_req_addr_64),
    .mem_rsp_valid(mem_rsp_valid_64), .mem_rsp_data(mem_rsp_data_64),
    .rsp_valid(rsp_valid_64), .rsp_ready(rsp_ready_64), .rsp_data(rsp_data_64),
    .rsp_split(rsp_split_64), .rsp_err(rsp_err_64), .dbg_state(dbg_state_64)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One load on the 32-bit unit; the first read is held off for mstall
  // cycles and the result for rstall cycles.
  task automatic run32(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input int mstall, input int rstall,
                       input logic [31:0] exp_data, input logic exp_split, input logic exp_err,
                       input int exp_reads, input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    logic [31:0] got_a[2];
    logic [31:0] held_addr;
    logic [31:0] held_data;
    logic        ready_seen = 1'b0;
    logic        addr_moved = 1'b0;
    logic        data_moved = 1'b0;
    logic        valid_drop = 1'b0;
    int          reads = 0;
    int          cyc = 0;
    int          stall = mstall;
    got_a[0] = '0;
    got_a[1] = '0;
    check_val({tag, ".req_ready_idle"}, 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    @(negedge clk);
    req_valid = 1'b0;
    held_addr = mem_req_addr;
    while (!rsp_valid && cyc < 60) begin
      ready_seen |= req_ready;
      if (mem_req_valid && reads < 2) begin
        if (stall > 0) begin
          if (mem_req_addr !== held_addr) addr_moved = 1'b1;
          stall--;
          @(negedge clk);
        end else begin
          if (mem_req_addr !== held_addr) addr_moved = 1'b1;
          got_a[reads]  = mem_req_addr;
          mem_req_ready = 1'b1;
          @(negedge clk);
          mem_req_ready = 1'b0;
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = (reads == 0) ? w0 : w1;
          reads++;
          @(negedge clk);
          mem_rsp_valid = 1'b0;
          mem_rsp_data  = 32'hDEAD_0000;
          held_addr     = mem_req_addr;
        end
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check_val({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    check_val({tag, ".rsp_data"}, 64'(rsp_data), 64'(exp_data));
    check_val({tag, ".rsp_split"}, 64'(rsp_split), 64'(exp_split));
    check_val({tag, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
    check_val({tag, ".reads"}, 64'(reads), 64'(exp_reads));
    if (exp_reads > 0) check_val({tag, ".addr0"}, 64'(got_a[0]), 64'(exp_a0));
    if (exp_reads > 1) check_val({tag, ".addr1"}, 64'(got_a[1]), 64'(exp_a1));
    if (mstall > 0) begin
      check_val({tag, ".req_ready_busy"}, 64'(ready_seen), 64'd0);
      check_val({tag, ".addr_stable"}, 64'(addr_moved), 64'd0);
    end
    held_data = rsp_data;
    for (int i = 0; i < rstall; i++) begin
      @(negedge clk);
      if (!rsp_valid) valid_drop = 1'b1;
      if (rsp_data !== held_data) data_moved = 1'b1;
      ready_seen |= req_ready;
    end
    if (rstall > 0) begin
      check_val({tag, ".rsp_held"}, 64'(valid_drop), 64'd0);
      check_val({tag, ".rsp_data_stable"}, 64'(data_moved), 64'd0);
      check_val({tag, ".req_ready_in_resp"}, 64'(ready_seen), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val({tag, ".single_rsp"}, 64'(rsp_valid), 64'd0);
    check_val({tag, ".back_idle"}, 64'(req_ready), 64'd1);
  endtask

  // One load on the 64-bit unit, no stalls.
  task automatic run64(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [63:0] w0, input logic [63:0] w1,
                       input logic [63:0] exp_data, input logic exp_split,
                       input int exp_reads, input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    logic [31:0] got_a[2];
    int reads = 0;
    int cyc = 0;
    got_a[0] = '0;
    got_a[1] = '0;
    req_valid_64  = 1'b1;
    req_addr_64   = addr;
    req_funct3_64 = f3;
    @(negedge clk);
    req_valid_64 = 1'b0;
    while (!rsp_valid_64 && cyc < 60) begin
      if (mem_req_valid_64 && reads < 2) begin
        got_a[reads]     = mem_req_addr_64;
        mem_req_ready_64 = 1'b1;
        @(negedge clk);
        mem_req_ready_64 = 1'b0;
        mem_rsp_valid_64 = 1'b1;
        mem_rsp_data_64  = (reads == 0) ? w0 : w1;
        reads++;
        @(negedge clk);
        mem_rsp_valid_64 = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check_val({tag, ".rsp_valid"}, 64'(rsp_valid_64), 64'd1);
    check_val({tag, ".rsp_data"}, rsp_data_64, exp_data);
    check_val({tag, ".rsp_split"}, 64'(rsp_split_64), 64'(exp_split));
    check_val({tag, ".rsp_err"}, 64'(rsp_err_64), 64'd0);
    check_val({tag, ".reads"}, 64'(reads), 64'(exp_reads));
    check_val({tag, ".addr0"}, 64'(got_a[0]), 64'(exp_a0));
    if (exp_reads > 1) check_val({tag, ".addr1"}, 64'(got_a[1]), 64'(exp_a1));
    rsp_ready_64 = 1'b1;
    @(negedge clk);
    rsp_ready_64 = 1'b0;
    check_val({tag, ".back_idle"}, 64'(req_ready_64), 64'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("reset.req_ready", 64'(req_ready), 64'd1);
    check_val("reset.mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_val("reset.mem_req_addr", 64'(mem_req_addr), 64'd0);
    check_val("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("reset.rsp_data", 64'(rsp_data), 64'd0);
    check_val("reset.rsp_err", 64'(rsp_err), 64'd0);
    check_val("reset64.rsp_data", rsp_data_64, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run32("lb_neg",   32'h0000_0103, LB,  32'h80FF_1234, 32'h0, 0, 0, 32'hFFFF_FF80, 1'b0, 1'b0, 1, 32'h100, 32'h0);
    run32("lhu_split",32'h0000_0103, LHU, 32'hAB00_0000, 32'h0000_00CD, 0, 0, 32'h0000_CDAB, 1'b1, 1'b0, 2, 32'h100, 32'h104);
    run32("lw_wrap",  32'hFFFF_FFFE, LW,  32'h1234_0000, 32'h0000_5678, 0, 0, 32'h5678_1234, 1'b1, 1'b0, 2, 32'hFFFF_FFFC, 32'h0);
    run32("lw_align", 32'h0000_0010, LW,  32'hDEAD_BEEF, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 32'h10, 32'h0);
    run32("lbu",      32'h0000_0101, LBU, 32'h0000_9A00, 32'h0, 0, 0, 32'h0000_009A, 1'b0, 1'b0, 1, 32'h100, 32'h0);
    run32("lh_pos",   32'h0000_0101, LH,  32'h007F_FE00, 32'h0, 0, 0, 32'h0000_7FFE, 1'b0, 1'b0, 1, 32'h100, 32'h0);
    run32("lw_split", 32'h0000_0105, LW,  32'h3322_11AA, 32'h0000_0044, 0, 0, 32'h4433_2211, 1'b1, 1'b0, 2, 32'h104, 32'h108);
    run32("ld_on32",  32'h0000_0100, LD,  32'h1111_1111, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1, 0, 32'h0, 32'h0);
    run32("lwu_on32", 32'h0000_0100, LWU, 32'h1111_1111, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1, 0, 32'h0, 32'h0);
    run32("stall_lh", 32'h0000_0202, LH,  32'h8001_5555, 32'h0, 4, 3, 32'hFFFF_8001, 1'b0, 1'b0, 1, 32'h200, 32'h0);

    run64("lwu64", 32'h0000_0004, LWU, 64'h8765_4321_0000_0000, 64'h0, 64'h0000_0000_8765_4321, 1'b0, 1, 32'h0, 32'h0);
    run64("lw64",  32'h0000_0004, LW,  64'h8765_4321_0000_0000, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b0, 1, 32'h0, 32'h0);
    run64("ld_split", 32'h0000_000C, LD, 64'h4433_2211_0000_0000, 64'hAAAA_AAAA_8877_6655,
          64'h8877_6655_4433_2211, 1'b1, 2, 32'h8, 32'h10);

    // Reset while waiting for the second word of a split load.
    req_valid = 1'b1; req_addr = 32'h0000_0103; req_funct3 = LHU;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAB00_0000;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check_val("rst_mid.in_wait1", 64'(dbg_state), 64'(ST_WAIT1));
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid.state", 64'(dbg_state), 64'(ST_IDLE));
    check_val("rst_mid.req_ready", 64'(req_ready), 64'd1);
    check_val("rst_mid.mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_val("rst_mid.rsp_data", 64'(rsp_data), 64'd0);
    check_val("rst_mid.rsp_split", 64'(rsp_split), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_00CD;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check_val("rst_mid.late_rsp_ignored", 64'(rsp_valid), 64'd0);
    check_val("rst_mid.still_idle", 64'(req_ready), 64'd1);
    run32("lb_after_rst", 32'h0000_0042, LB, 32'h0055_0000, 32'h0, 0, 0, 32'h0000_0055, 1'b0, 1'b0, 1, 32'h40, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
